// File: rtl/pc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_pkg : opcode encodings and width helper for the PC sequencer       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pc_pkg;

    localparam logic [1:0] JMP_FAMILY = 2'b11;

    localparam logic [1:0] OP_JC   = 2'b00;
    localparam logic [1:0] OP_JMP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    function automatic int instr_width(input int opc_w, input int opr_w);
        return opc_w + 2 * opr_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_return_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_return_stack : LIFO of return addresses for CALL/RET               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pc_return_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               Clock,
    input  logic                               Reset,
    input  logic                               push,
    input  logic                               pop,
    input  logic [ADDR_W-1:0]                  push_data,
    output logic [ADDR_W-1:0]                  top,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   level,
    output logic                               full,
    output logic                               empty
);

    localparam int LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] r_entry [STACK_DEPTH];
    logic [LVL_W-1:0]  r_level;
    logic [LVL_W-1:0]  w_level_m1;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;

    // Index slices are only meaningful when the matching push/pop is legal.
    assign w_level_m1 = r_level - LVL_W'(1);
    assign w_wr_idx   = r_level[IDX_W-1:0];
    assign w_rd_idx   = w_level_m1[IDX_W-1:0];

    assign full  = (r_level == LVL_W'(STACK_DEPTH));
    assign empty = (r_level == '0);
    assign level = r_level;
    assign top   = r_entry[w_rd_idx];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_level <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else if (push && !full) begin
            r_entry[w_wr_idx] <= push_data;
            r_level           <= r_level + LVL_W'(1);
        end else if (pop && !empty) begin
            r_level <= w_level_m1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_sequencer : program counter, jump decode and return-stack control |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int OPC_W       = 4,
    parameter int OPR_W       = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                                      Clock,
    input  logic                                      Reset,
    input  logic                                      Stall,
    input  logic                                      DoJump,
    output logic [ADDR_W-1:0]                         ImemAddr,
    input  logic [instr_width(OPC_W, OPR_W)-1:0]      ImemData,
    output logic [OPC_W-1:0]                          command,
    output logic [OPR_W-1:0]                          A,
    output logic [OPR_W-1:0]                          B,
    output logic                                      Taken,
    output logic [$clog2(STACK_DEPTH+1)-1:0]          StackLevel,
    output logic                                      StackErr
);

    localparam int IW    = instr_width(OPC_W, OPR_W);
    localparam int TGT_W = 2 * OPR_W;

    logic [ADDR_W-1:0] r_pc;
    logic              r_err;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_stack_top;
    logic [TGT_W-1:0]  w_tgt_raw;
    logic [1:0]        w_family;
    logic [1:0]        w_subop;
    logic              w_push;
    logic              w_pop;
    logic              w_err_set;
    logic              w_full;
    logic              w_empty;

    assign command  = ImemData[IW-1 -: OPC_W];
    assign A        = ImemData[2*OPR_W-1 : OPR_W];
    assign B        = ImemData[OPR_W-1 : 0];
    assign ImemAddr = r_pc;
    assign StackErr = r_err;

    assign w_family  = command[OPC_W-1 -: 2];
    assign w_subop   = command[1:0];
    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_tgt_raw = {A, B};

    generate
        if (ADDR_W > TGT_W) begin : g_tgt_zext
            assign w_target = {{(ADDR_W-TGT_W){1'b0}}, w_tgt_raw};
        end else if (ADDR_W == TGT_W) begin : g_tgt_same
            assign w_target = w_tgt_raw;
        end else begin : g_tgt_trunc
            assign w_target = w_tgt_raw[ADDR_W-1:0];
        end
    endgenerate

    // Refused CALL/RET fall through to PC+1 and raise the sticky error.
    always_comb begin
        w_next_pc = w_pc_inc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
        Taken     = 1'b0;
        if (w_family == JMP_FAMILY) begin
            case (w_subop)
                OP_JC: begin
                    Taken = DoJump;
                    if (DoJump) w_next_pc = w_target;
                end
                OP_JMP: begin
                    Taken     = 1'b1;
                    w_next_pc = w_target;
                end
                OP_CALL: begin
                    if (!w_full) begin
                        Taken     = 1'b1;
                        w_push    = 1'b1;
                        w_next_pc = w_target;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
                default: begin
                    if (!w_empty) begin
                        Taken     = 1'b1;
                        w_pop     = 1'b1;
                        w_next_pc = w_stack_top;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pc  <= '0;
            r_err <= 1'b0;
        end else if (!Stall) begin
            r_pc <= w_next_pc;
            if (w_err_set) r_err <= 1'b1;
        end
    end

    pc_return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .Clock     (Clock),
        .Reset     (Reset),
        .push      (w_push && !Stall),
        .pop       (w_pop && !Stall),
        .push_data (w_pc_inc),
        .top       (w_stack_top),
        .level     (StackLevel),
        .full      (w_full),
        .empty     (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_sequencer : directed scoreboard bench for pc_sequencer          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_pc_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        DoJump;
    logic [7:0]  ImemAddr;
    logic [11:0] ImemData;
    logic [3:0]  command;
    logic [3:0]  A;
    logic [3:0]  B;
    logic        Taken;
    logic [2:0]  StackLevel;
    logic        StackErr;

    logic [11:0] rom [256];

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] pc;
        logic [2:0] lvl;
        logic       err;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    always #5 Clock = ~Clock;

    assign ImemData = rom[ImemAddr];

    pc_sequencer #(
        .ADDR_W      (8),
        .OPC_W       (4),
        .OPR_W       (4),
        .STACK_DEPTH (4)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Stall      (Stall),
        .DoJump     (DoJump),
        .ImemAddr   (ImemAddr),
        .ImemData   (ImemData),
        .command    (command),
        .A          (A),
        .B          (B),
        .Taken      (Taken),
        .StackLevel (StackLevel),
        .StackErr   (StackErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the state expected after the next edge.
    task automatic expect_next(input string tag, input logic [7:0] pc,
                               input logic [2:0] lvl, input logic err);
        exp_t e;
        e.pc  = pc;
        e.lvl = lvl;
        e.err = err;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic tick_check();
        exp_t  e;
        string t;
        @(posedge Clock);
        #1;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            chk({t, "_pc"},  32'(ImemAddr),   32'(e.pc));
            chk({t, "_lvl"}, 32'(StackLevel), 32'(e.lvl));
            chk({t, "_err"}, 32'(StackErr),   32'(e.err));
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        expect_next("reset", 8'h00, 3'd0, 1'b0);
        tick_check();
        Reset = 1'b0;
    endtask

    task automatic advance(input int n, input logic [2:0] lvl, input logic err);
        for (int i = 0; i < n; i++) begin
            expect_next("adv", ImemAddr + 8'd1, lvl, err);
            tick_check();
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    endtask

    initial begin
        Reset  = 1'b1;
        Stall  = 1'b0;
        DoJump = 1'b0;
        clear_rom();

        // Free-run over NOPs including the wrap from 0xFF to 0x00
        do_reset();
        chk("nop_taken", 32'(Taken), 32'd0);
        for (int i = 1; i <= 256; i++) begin
            expect_next("freerun", 8'(i), 3'd0, 1'b0);
            tick_check();
        end
        chk("wrap_pc", 32'(ImemAddr), 32'h00);

        // Conditional jump, not taken then taken
        rom[8'h05] = 12'hC3A;
        do_reset();
        advance(5, 3'd0, 1'b0);
        chk("jc_cmd", 32'(command), 32'hC);
        chk("jc_a",   32'(A),       32'h3);
        chk("jc_b",   32'(B),       32'hA);
        chk("jc0_taken", 32'(Taken), 32'd0);
        expect_next("jc0", 8'h06, 3'd0, 1'b0);
        tick_check();
        do_reset();
        advance(5, 3'd0, 1'b0);
        DoJump = 1'b1;
        #1;
        chk("jc1_taken", 32'(Taken), 32'd1);
        expect_next("jc1", 8'h3A, 3'd0, 1'b0);
        tick_check();
        DoJump = 1'b0;

        // Single CALL / RET
        clear_rom();
        rom[8'h10] = 12'hE40;
        rom[8'h40] = 12'hF00;
        do_reset();
        advance(16, 3'd0, 1'b0);
        chk("call_taken", 32'(Taken), 32'd1);
        expect_next("call", 8'h40, 3'd1, 1'b0);
        tick_check();
        chk("ret_taken", 32'(Taken), 32'd1);
        expect_next("ret", 8'h11, 3'd0, 1'b0);
        tick_check();

        // Nested CALLs overflowing a 4-deep stack
        clear_rom();
        rom[8'h00] = 12'hE10;
        rom[8'h10] = 12'hE20;
        rom[8'h20] = 12'hE30;
        rom[8'h30] = 12'hE40;
        rom[8'h40] = 12'hE50;
        rom[8'h41] = 12'hF00;
        do_reset();
        expect_next("call1", 8'h10, 3'd1, 1'b0); tick_check();
        expect_next("call2", 8'h20, 3'd2, 1'b0); tick_check();
        expect_next("call3", 8'h30, 3'd3, 1'b0); tick_check();
        expect_next("call4", 8'h40, 3'd4, 1'b0); tick_check();
        chk("call5_taken", 32'(Taken), 32'd0);
        expect_next("call5", 8'h41, 3'd4, 1'b1); tick_check();
        expect_next("ret4", 8'h31, 3'd3, 1'b1); tick_check();

        // RET on empty stack, then reset clears the error
        clear_rom();
        rom[8'h20] = 12'hF00;
        do_reset();
        advance(32, 3'd0, 1'b0);
        chk("ret_empty_taken", 32'(Taken), 32'd0);
        expect_next("ret_empty", 8'h21, 3'd0, 1'b1);
        tick_check();
        do_reset();

        // CALL at the last address pushes 0
        clear_rom();
        rom[8'h00] = 12'hDFF;
        rom[8'hFF] = 12'hE80;
        rom[8'h80] = 12'hF00;
        do_reset();
        expect_next("jmp_ff", 8'hFF, 3'd0, 1'b0); tick_check();
        expect_next("call_ff", 8'h80, 3'd1, 1'b0); tick_check();
        expect_next("ret_wrap", 8'h00, 3'd0, 1'b0); tick_check();

        // Stall holds PC over a JMP, and holds the stack over a CALL
        clear_rom();
        rom[8'h00] = 12'hD77;
        rom[8'h77] = 12'hE05;
        do_reset();
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_jmp_taken", 32'(Taken), 32'd1);
            expect_next("stall_jmp", 8'h00, 3'd0, 1'b0);
            tick_check();
        end
        Stall = 1'b0;
        expect_next("unstall_jmp", 8'h77, 3'd0, 1'b0);
        tick_check();
        Stall = 1'b1;
        chk("stall_call_taken", 32'(Taken), 32'd1);
        expect_next("stall_call", 8'h77, 3'd0, 1'b0);
        tick_check();
        expect_next("reset_stall", 8'h00, 3'd0, 1'b0);
        Reset = 1'b1;
        tick_check();
        Reset = 1'b0;
        Stall = 1'b0;

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter and fetch sequencer for the 4-bit CPU family, and the successor to the fixed 8-bit PC-plus-ROM block. It drives an external instruction memory and splits the returned word into command and two operand fields. It supports conditional and unconditional jumps, CALL/RET through a hardware return stack, and a stall input. It sits between the instruction ROM and the decode/ALU stage.

Parameters:
ADDR_W, 8, PC / instruction-address width in bits.
OPC_W, 4, opcode (command) field width; must be at least 2.
OPR_W, 4, width of each operand field A and B; instruction width IW = OPC_W + 2*OPR_W.
STACK_DEPTH, 4, number of return-stack entries; must be at least 1.

Ports:
Clock  in  1  system clock, rising edge.
Reset  in  1  synchronous, active-high reset.
Stall  in  1  hold PC and stack this cycle.
DoJump  in  1  condition flag for the conditional jump.
ImemAddr  out  ADDR_W  instruction address; equals the PC register.
ImemData  in  IW  instruction word, combinational read of ImemAddr.
command  out  OPC_W  ImemData[IW-1 -: OPC_W].
A  out  OPR_W  ImemData[2*OPR_W-1 : OPR_W].
B  out  OPR_W  ImemData[OPR_W-1 : 0].
Taken  out  1  current instruction redirects the PC next edge (combinational).
StackLevel  out  clog2(STACK_DEPTH+1)  number of occupied stack entries.
StackErr  out  1  sticky overflow/underflow flag.

Behaviour:
- Clock is the only clock. Reset is synchronous and active-high.
- On Reset at a rising edge: PC=0, StackLevel=0, StackErr=0, all stack entries=0. Reset has priority over everything else.
- command, A and B are pure slices of ImemData with zero added latency. Taken is combinational.
- Jump family: top two opcode bits = 2'b11. The low two bits select the operation:
  - 00 JC: taken if DoJump=1.
  - 01 JMP: always taken.
  - 10 CALL: taken if the stack is not full.
  - 11 RET: taken if the stack is not empty.
- Any other opcode is non-jump.
- Target = {A,B}, zero-extended or truncated to ADDR_W.
- Next PC per rising edge, in priority order:
  1. Reset.
  2. Stall=1: PC, stack and StackErr all hold; Taken is still driven combinationally.
  3. JC/JMP taken: PC <= target.
  4. CALL taken: push PC+1 (mod 2^ADDR_W); PC <= target.
  5. RET taken: PC <= top entry; pop.
  6. Otherwise: PC <= PC+1 (mod 2^ADDR_W).
- Wrap-around: PC=2^ADDR_W-1 increments to 0. A CALL at the last address pushes 0.
- CALL with StackLevel=STACK_DEPTH: no push, PC <= PC+1, StackErr <= 1.
- RET with StackLevel=0: PC <= PC+1, StackErr <= 1.
- StackErr is cleared only by Reset.
- Stack is LIFO. Push writes entry[StackLevel] and then increments; pop reads entry[StackLevel-1] and then decrements.
- No internal ROM. The single cycle of fetch latency is the caller's responsibility, and ImemData must be valid combinationally.

Decomposition:
- Package pc_pkg holds:
  - opcode family constant JMP_FAMILY = 2'b11.
  - sub-op constants OP_JC=2'b00, OP_JMP=2'b01, OP_CALL=2'b10, OP_RET=2'b11.
  - a function that derives IW from the parameters.
- Sub-module pc_return_stack (parameters ADDR_W, STACK_DEPTH):
  - inputs: push, pop, push_data.
  - outputs: top, level, full, empty.
  - same Clock and Reset.
- The top level holds the PC register, decode and next-PC mux.

Test Plan:
1. Reset then free-run with ROM of NOPs (0x000), ADDR_W=8 -> ImemAddr counts 0,1,2…; after 255 it reads 0; StackLevel=0.
2. Instr at 0x05 = 0xC3A (JC, target 0x3A): with DoJump=0 -> next PC 0x06, Taken=0; with DoJump=1 -> next PC 0x3A, Taken=1.
3. CALL 0xE40 at 0x10, RET 0xF00 at 0x40 -> PC sequence 0x10, 0x40, 0x11; StackLevel 0→1→0; StackErr=0.
4. Nested CALLs 5 deep with STACK_DEPTH=4 -> the first 4 are taken with StackLevel=4; the 5th yields PC+1 and StackErr=1; a following RET returns to the 4th call's return address.
5. RET with an empty stack at 0x20 -> PC 0x21 and StackErr=1; Reset -> StackErr=0 and PC=0.
6. Stall=1 held 3 cycles on a JMP 0xD77 -> PC and StackLevel unchanged while Taken=1; Stall released -> PC=0x77. Repeat with Reset asserted together with Stall -> PC=0.
